snn_tdm_core: RTL and testbench

//  Parametrised successor to the fixed 4-input/2-output SNN top. It takes NUM_IN binary spike channels,
//  NUM_OUT leaky integrate-and-fire (LIF) neurons and a runtime-writable signed weight matrix.
//  - Accumulation is time-multiplexed over inputs: one input row per cycle, all outputs in parallel.
//  - Adds a refractory period, optional winner-take-all lateral inhibition and saturating per-neuron spike counters.
//  - Sits between the input encoder neurons and the motor/decision logic.

---
 rtl/snn_tdm_core_pkg.sv | 19 +
 rtl/snn_tdm_core_lif_unit.sv | 81 ++++++++
 rtl/snn_tdm_core.sv | 188 ++++++++++++++++++
 tb/tb_snn_tdm_core.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_tdm_core_pkg.sv
// Shared types and helpers for the time-multiplexed SNN core and its LIF units.
package snn_tdm_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Ceiling log2, never below 1 so derived vector widths stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/snn_tdm_core_lif_unit.sv
// One leaky integrate-and-fire neuron: row accumulator, membrane, refractory counter.
// Arbitration between neurons is left to the parent; this unit only proposes fire_cand.
module lif_unit
  import snn_tdm_core_pkg::*;
#(
  parameter int WW         = 16,
  parameter int VW         = 16,
  parameter int AW         = 19,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_acc,
  input  logic                 acc_en,
  input  logic signed [WW-1:0] acc_add,
  input  logic                 upd,
  input  logic                 win,
  input  logic signed [VW-1:0] thr,
  output logic signed [VW-1:0] v_next,
  output logic                 fire_cand
);

  localparam int RW = clog2(REFRAC + 1);
  localparam int SW = ((VW > AW) ? VW : AW) + 2;
  localparam logic signed [SW-1:0] SUM_MAX = {{(SW-VW+1){1'b0}}, {(VW-1){1'b1}}};
  localparam logic signed [SW-1:0] SUM_MIN = {{(SW-VW+1){1'b1}}, {(VW-1){1'b0}}};
  localparam logic signed [VW-1:0] V_MAX   = {1'b0, {(VW-1){1'b1}}};
  localparam logic signed [VW-1:0] V_MIN   = {1'b1, {(VW-1){1'b0}}};

  logic signed [AW-1:0] acc;
  logic signed [VW-1:0] v;
  logic [RW-1:0]        refr;
  logic signed [SW-1:0] v_ext;
  logic signed [SW-1:0] acc_ext;
  logic signed [SW-1:0] sum;

  // Wide enough that leak plus a full accumulator cannot wrap before clamping.
  assign v_ext   = {{(SW-VW){v[VW-1]}}, v};
  assign acc_ext = {{(SW-AW){acc[AW-1]}}, acc};
  assign sum     = v_ext - (v_ext >>> LEAK_SHIFT) + acc_ext;

  always_comb begin
    if (sum > SUM_MAX) begin
      v_next = V_MAX;
    end else if (sum < SUM_MIN) begin
      v_next = V_MIN;
    end else begin
      v_next = sum[VW-1:0];
    end
  end

  assign fire_cand = (refr == '0) && (v_next >= thr);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      v    <= '0;
      refr <= '0;
    end else begin
      if (clr_acc) begin
        acc <= '0;
      end else if (acc_en) begin
        acc <= acc + {{(AW-WW){acc_add[WW-1]}}, acc_add};
      end
      if (upd) begin
        if (refr != '0) begin
          v    <= '0;
          refr <= refr - RW'(1);
        end else if (fire_cand) begin
          // Inhibited candidates are also reset, but skip the refractory period.
          v <= '0;
          if (win) refr <= RW'(REFRAC);
        end else begin
          v <= v_next;
        end
      end
    end
  end

endmodule

// File: rtl/snn_tdm_core.sv
// Time-multiplexed LIF layer: one input row per cycle, all neurons in parallel,
// optional winner-take-all, saturating spike counters and an IDLE-only weight port.
//
//   state     | meaning
//   ST_IDLE   | waiting for step; weight writes accepted
//   ST_ACCUM  | add weight row idx (0..NUM_IN-1) into every accumulator
//   ST_UPDATE | leak/integrate/fire, register out_spike, bump counters
//   ST_DONE   | out_valid pulse, then back to IDLE
module snn_tdm_core
  import snn_tdm_core_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int NUM_OUT    = 2,
  parameter int WW         = 16,
  parameter int VW         = 16,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2,
  parameter int CW         = 8,
  parameter int INH_EN     = 0,
  localparam int ADDR_W    = clog2(NUM_IN * NUM_OUT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      step,
  input  logic [NUM_IN-1:0]         in_spike,
  input  logic signed [VW-1:0]      thr,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic signed [WW-1:0]      wr_data,
  output logic                      wr_ack,
  output logic                      busy,
  output logic                      out_valid,
  output logic [NUM_OUT-1:0]        out_spike,
  output logic [NUM_OUT*CW-1:0]     spike_cnt,
  input  logic                      cnt_clr
);

  localparam int IW = clog2(NUM_IN);
  localparam int AW = WW + clog2(NUM_IN) + 1;
  localparam int NW = NUM_IN * NUM_OUT;
  localparam logic [IW-1:0]   IDX_LAST = IW'(NUM_IN - 1);
  localparam logic [ADDR_W:0] NW_LIM   = (ADDR_W + 1)'(NW);
  localparam logic [CW-1:0]   CNT_MAX  = '1;

  state_t                state;
  state_t                state_nx;
  logic [IW-1:0]         idx;
  logic [NUM_IN-1:0]     in_q;
  logic signed [WW-1:0]  w_mem [NW];
  logic                  step_acc;
  logic                  acc_en;
  logic                  upd;
  logic                  wr_ok;
  logic [NUM_OUT-1:0]    fire_cand;
  logic [NUM_OUT-1:0]    fire;
  logic signed [VW-1:0]  v_next [NUM_OUT];
  logic                  win_found;
  logic signed [VW-1:0]  best_v;

  always_comb begin
    state_nx = state;
    step_acc = 1'b0;
    acc_en   = 1'b0;
    upd      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (step && en) begin
          state_nx = ST_ACCUM;
          step_acc = 1'b1;
        end
      end
      ST_ACCUM: begin
        acc_en = en;
        if (en && (idx == IDX_LAST)) state_nx = ST_UPDATE;
      end
      ST_UPDATE: begin
        upd = en;
        if (en) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (en) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      in_q  <= '0;
    end else begin
      state <= state_nx;
      if (step_acc) begin
        idx  <= '0;
        in_q <= in_spike;
      end else if (acc_en && (idx != IDX_LAST)) begin
        idx <= idx + IW'(1);
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // Writes ignore en but never land mid-timestep, so a row cannot change under ACCUM.
  assign wr_ok = wr_en && (state == ST_IDLE) && ({1'b0, wr_addr} < NW_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ack <= 1'b0;
      for (int i = 0; i < NW; i++) w_mem[i] <= '0;
    end else begin
      wr_ack <= wr_ok;
      if (wr_ok) w_mem[wr_addr] <= wr_data;
    end
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    win_found = 1'b0;
    best_v    = '0;
    fire      = '0;
    if (INH_EN != 0) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (fire_cand[k] && (!win_found || (v_next[k] > best_v))) begin
          win_found = 1'b1;
          best_v    = v_next[k];
          fire      = '0;
          fire[k]   = 1'b1;
        end
      end
    end else begin
      fire = fire_cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_spike <= '0;
    end else if (upd) begin
      out_spike <= fire;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_lif
    logic [ADDR_W-1:0]    rd_addr;
    logic signed [WW-1:0] add;
    logic [CW-1:0]        cnt;

    assign rd_addr = ADDR_W'(int'(idx) * NUM_OUT + k);
    assign add     = in_q[idx] ? w_mem[rd_addr] : '0;

    lif_unit #(
      .WW         (WW),
      .VW         (VW),
      .AW         (AW),
      .LEAK_SHIFT (LEAK_SHIFT),
      .REFRAC     (REFRAC)
    ) u_lif (
      .clk       (clk),
      .rst       (rst),
      .clr_acc   (step_acc),
      .acc_en    (acc_en),
      .acc_add   (add),
      .upd       (upd),
      .win       (fire[k]),
      .thr       (thr),
      .v_next    (v_next[k]),
      .fire_cand (fire_cand[k])
    );

    // Clear wins over counting, but a coincident spike is still recorded.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (cnt_clr) begin
        cnt <= (upd && fire[k]) ? CW'(1) : '0;
      end else if (upd && fire[k] && (cnt != CNT_MAX)) begin
        cnt <= cnt + CW'(1);
      end
    end

    assign spike_cnt[k*CW +: CW] = cnt;
  end

endmodule

// File: tb/tb_snn_tdm_core.sv
// Directed bench: default core (dut_a) and a WTA core with 4-bit counters (dut_b) share stimulus.
module tb_snn_tdm_core;

  logic        clk;
  logic        rst;
  logic        en;
  logic        step;
  logic [3:0]  in_spike;
  logic [15:0] thr;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        cnt_clr;

  logic        a_wr_ack, a_busy, a_out_valid;
  logic [1:0]  a_out_spike;
  logic [15:0] a_spike_cnt;
  logic        b_wr_ack, b_busy, b_out_valid;
  logic [1:0]  b_out_spike;
  logic [7:0]  b_spike_cnt;

  int checks;
  int errors;

  snn_tdm_core dut_a (
    .clk(clk), .rst(rst), .en(en), .step(step), .in_spike(in_spike), .thr(thr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(a_wr_ack),
    .busy(a_busy), .out_valid(a_out_valid), .out_spike(a_out_spike),
    .spike_cnt(a_spike_cnt), .cnt_clr(cnt_clr)
  );

  snn_tdm_core #(.CW(4), .INH_EN(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .step(step), .in_spike(in_spike), .thr(thr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(b_wr_ack),
    .busy(b_busy), .out_valid(b_out_valid), .out_spike(b_out_spike),
    .spike_cnt(b_spike_cnt), .cnt_clr(cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; step = 1'b0; in_spike = '0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; cnt_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic write_w(input int addr, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = 3'(addr); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_step(input logic [3:0] spk, output logic [1:0] sa, output logic [1:0] sb);
    int n;
    step = 1'b1; in_spike = spk;
    tick();
    step = 1'b0;
    n = 0;
    while (a_out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL step_timeout out_valid not seen within %0d cycles", n);
    end
    sa = a_out_spike;
    sb = b_out_spike;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", a_busy); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", a_out_valid); end
    checks++; if (a_out_spike !== 2'b00) begin errors++; $display("FAIL reset_spike got %b exp 00", a_out_spike); end
    checks++; if (a_spike_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt got %h exp 0000", a_spike_cnt); end
    checks++; if (a_wr_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %0b exp 0", a_wr_ack); end
  endtask

  task automatic test_basic_lif();
    logic [11:0] tbl;
    logic [1:0]  sa, sb;
    tbl = 12'b01_00_00_00_01_00;  // step6..step1 expected out_spike
    do_reset();
    thr = 16'd150;
    write_w(0, 16'd100);
    checks++; if (a_wr_ack !== 1'b1) begin errors++; $display("FAIL basic_wr_ack got %0b exp 1", a_wr_ack); end
    for (int i = 0; i < 6; i++) begin
      do_step(4'b0001, sa, sb);
      checks++;
      if (sa !== tbl[2*i +: 2]) begin
        errors++; $display("FAIL basic_step%0d got %b exp %b", i + 1, sa, tbl[2*i +: 2]);
      end
      if (i == 4) begin
        checks++; if (a_spike_cnt !== 16'h0001) begin errors++; $display("FAIL basic_cnt got %h exp 0001", a_spike_cnt); end
      end
    end
  endtask

  task automatic test_latency();
    logic [1:0] sp, sa, sb;
    do_reset();
    thr = 16'd150;
    write_w(0, 16'd100);
    sp = 2'b11;
    in_spike = 4'b0001; step = 1'b1;
    tick();
    step = 1'b0; in_spike = 4'b0000;
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (a_busy !== (c <= 6)) begin errors++; $display("FAIL lat_busy t+%0d got %0b exp %0b", c, a_busy, (c <= 6)); end
      checks++;
      if (a_out_valid !== (c == 6)) begin errors++; $display("FAIL lat_valid t+%0d got %0b exp %0b", c, a_out_valid, (c == 6)); end
      if (c == 3) begin
        checks++; if (a_wr_ack !== 1'b0) begin errors++; $display("FAIL lat_busy_wr_ack got %0b exp 0", a_wr_ack); end
      end
      if (c == 6) sp = a_out_spike;
      wr_en = (c == 2); wr_addr = 3'd0; wr_data = 16'd0;
      step = (c == 3);
      tick();
    end
    wr_en = 1'b0; step = 1'b0;
    checks++; if (sp !== 2'b00) begin errors++; $display("FAIL lat_spike got %b exp 00", sp); end
    do_step(4'b0001, sa, sb);
    checks++; if (sa !== 2'b01) begin errors++; $display("FAIL lat_weight_kept got %b exp 01", sa); end
  endtask

  task automatic test_saturation();
    logic [1:0] sa, sb;
    do_reset();
    thr = 16'h7fff;
    for (int i = 0; i < 8; i++) write_w(i, 16'h7fff);
    do_step(4'b1111, sa, sb);
    checks++; if (sa !== 2'b11) begin errors++; $display("FAIL sat_pos got %b exp 11", sa); end
    checks++; if (sb !== 2'b01) begin errors++; $display("FAIL sat_pos_wta_tie got %b exp 01", sb); end
    do_reset();
    thr = 16'h0000;
    for (int i = 0; i < 8; i++) write_w(i, 16'h8000);
    do_step(4'b1111, sa, sb);
    checks++; if (sa !== 2'b00) begin errors++; $display("FAIL sat_neg1 got %b exp 00", sa); end
    checks++; if (sb !== 2'b00) begin errors++; $display("FAIL sat_neg1_wta got %b exp 00", sb); end
    do_step(4'b1111, sa, sb);
    checks++; if (sa !== 2'b00) begin errors++; $display("FAIL sat_neg2 got %b exp 00", sa); end
  endtask

  task automatic test_wta();
    logic [1:0] sa, sb;
    do_reset();
    thr = 16'd150;
    write_w(0, 16'd300);
    write_w(1, 16'd200);
    do_step(4'b0001, sa, sb);
    checks++; if (sa !== 2'b11) begin errors++; $display("FAIL wta_plain got %b exp 11", sa); end
    checks++; if (sb !== 2'b01) begin errors++; $display("FAIL wta_win got %b exp 01", sb); end
    write_w(0, 16'd0);
    write_w(1, 16'd0);
    do_step(4'b0001, sa, sb);
    checks++; if (sb !== 2'b00) begin errors++; $display("FAIL wta_loser_v0 got %b exp 00", sb); end
    do_reset();
    write_w(0, 16'd300);
    write_w(1, 16'd300);
    do_step(4'b0001, sa, sb);
    checks++; if (sb !== 2'b01) begin errors++; $display("FAIL wta_tie got %b exp 01", sb); end
    do_step(4'b0001, sa, sb);
    checks++; if (sb !== 2'b10) begin errors++; $display("FAIL wta_loser_norefrac got %b exp 10", sb); end
    checks++; if (sa !== 2'b00) begin errors++; $display("FAIL wta_plain_refrac got %b exp 00", sa); end
  endtask

  task automatic test_counters();
    logic [1:0] sa, sb;
    do_reset();
    thr = 16'd150;
    write_w(0, 16'd300);
    for (int i = 0; i < 60; i++) do_step(4'b0001, sa, sb);
    checks++; if (b_spike_cnt[3:0] !== 4'd15) begin errors++; $display("FAIL cnt_sat got %0d exp 15", b_spike_cnt[3:0]); end
    checks++; if (a_spike_cnt[7:0] !== 8'd20) begin errors++; $display("FAIL cnt_20 got %0d exp 20", a_spike_cnt[7:0]); end
    checks++; if (b_spike_cnt[7:4] !== 4'd0) begin errors++; $display("FAIL cnt_idle_neuron got %0d exp 0", b_spike_cnt[7:4]); end
    // step 61 fires; cnt_clr held through its UPDATE cycle (t+5)
    step = 1'b1; in_spike = 4'b0001;
    tick();
    step = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (b_out_spike !== 2'b01) begin errors++; $display("FAIL clr_step_spike got %b exp 01", b_out_spike); end
    checks++; if (b_spike_cnt[3:0] !== 4'd1) begin errors++; $display("FAIL clr_with_spike got %0d exp 1", b_spike_cnt[3:0]); end
    checks++; if (a_spike_cnt[7:0] !== 8'd1) begin errors++; $display("FAIL clr_with_spike_a got %0d exp 1", a_spike_cnt[7:0]); end
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (a_spike_cnt !== 16'h0000) begin errors++; $display("FAIL clr_only got %h exp 0000", a_spike_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] sa, sb;
    int seen;
    do_reset();
    thr = 16'd150;
    write_w(0, 16'd300);
    do_step(4'b0001, sa, sb);
    checks++; if (a_spike_cnt[7:0] !== 8'd1) begin errors++; $display("FAIL mid_pre_cnt got %0d exp 1", a_spike_cnt[7:0]); end
    step = 1'b1; in_spike = 4'b0001;
    tick();
    step = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b exp 0", a_busy); end
    checks++; if (a_spike_cnt !== 16'h0000) begin errors++; $display("FAIL mid_cnt_a got %h exp 0000", a_spike_cnt); end
    checks++; if (b_spike_cnt !== 8'h00) begin errors++; $display("FAIL mid_cnt_b got %h exp 00", b_spike_cnt); end
    checks++; if (a_out_spike !== 2'b00) begin errors++; $display("FAIL mid_spike got %b exp 00", a_out_spike); end
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (a_out_valid !== 1'b0) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_valid got %0d pulses exp 0", seen); end
    do_step(4'b0001, sa, sb);
    checks++; if (sa !== 2'b00) begin errors++; $display("FAIL mid_w_clear1 got %b exp 00", sa); end
    do_step(4'b0001, sa, sb);
    checks++; if (sa !== 2'b00) begin errors++; $display("FAIL mid_w_clear2 got %b exp 00", sa); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    thr = '0;
    test_reset();
    test_basic_lif();
    test_latency();
    test_saturation();
    test_wta();
    test_counters();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
